mem_bus_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-ported data memory bus of the MIPS CPU. It shares the memory interface (CS, WR_RD, ADDR, Data_BUS_WRITE, Data_BUS_READ) between the CPU data port (M0) and a secondary master such as a program loader or DMA (M1). It uses round-robin arbitration and runs each granted access as a fixed-latency transaction with a one-cycle acknowledge. It sits between the cpu data-port signals and the data memory, clocked by the system clock.

---
 rtl/mips_bus_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 30 +++
 rtl/mem_bus_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_bus_pkg.sv
// ---------------------------------------------------------------------------
// mips_bus_pkg
//   Shared definitions for the data-memory bus arbiter of the MIPS CPU.
//   - bus_state_t : transaction sequencer states
//   - BUS_WR/BUS_RD : WR_RD encoding used by both masters and the memory
//   - CNT_W : width of the memory-latency wait counter (MEM_LAT up to 15)
// ---------------------------------------------------------------------------
package mips_bus_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } bus_state_t;

    localparam logic BUS_WR = 1'b1;
    localparam logic BUS_RD = 1'b0;

    localparam int CNT_W = 4;

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Combinational two-way round-robin pick.
//   Ports:
//     req       in  [1:0]  request vector, bit i = master i
//     last      in         index of the master granted most recently
//     gnt_idx   out        index of the winning master
//     gnt_valid out        at least one request is present
//   On a tie the master that was not granted last wins. The LAST state
//   itself lives in the parent so this block stays purely combinational.
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_idx,
    output logic       gnt_valid
);

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = 1'b0;
        case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~last;
            default: gnt_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares the single-ported data memory bus between the CPU data port (M0)
//   and a secondary master (M1). Round-robin arbitration; each grant runs a
//   fixed-latency transaction: IDLE -> ACCESS (CS) -> MEM_LAT x WAIT -> DONE
//   (one-cycle ACK) -> IDLE.
//   Parameters:
//     ADDR_W, DATA_W : bus widths
//     MEM_LAT        : cycles from the CS cycle to valid Data_BUS_READ (1..15)
//   Ports:
//     CLK, RST (synchronous, active low)
//     Mx_REQ/Mx_WR_RD/Mx_ADDR/Mx_WDATA  master requests, held until ACK
//     Mx_ACK/Mx_RDATA                   completion pulse and read data
//     CS/WR_RD/ADDR/Data_BUS_WRITE      memory-side request (CS qualifies)
//     Data_BUS_READ                     memory read data
//     BUSY                              sequencer not in IDLE
//   Every output is driven straight from a register.
// ---------------------------------------------------------------------------
module mem_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              M0_REQ,
    input  logic              M0_WR_RD,
    input  logic [ADDR_W-1:0] M0_ADDR,
    input  logic [DATA_W-1:0] M0_WDATA,
    output logic              M0_ACK,
    output logic [DATA_W-1:0] M0_RDATA,
    input  logic              M1_REQ,
    input  logic              M1_WR_RD,
    input  logic [ADDR_W-1:0] M1_ADDR,
    input  logic [DATA_W-1:0] M1_WDATA,
    output logic              M1_ACK,
    output logic [DATA_W-1:0] M1_RDATA,
    output logic              CS,
    output logic              WR_RD,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] Data_BUS_WRITE,
    input  logic [DATA_W-1:0] Data_BUS_READ,
    output logic              BUSY
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    bus_state_t        state_reg, state_next;
    logic              last_reg, last_next;
    logic              winner_reg, winner_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              cs_reg, cs_next;
    logic              wr_rd_reg, wr_rd_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic              busy_reg;

    // Single-cycle strobes from the WAIT->DONE transition, consumed by the
    // per-master ACK / RDATA registers.
    logic              ack_set;
    logic              rd_capture;

    logic [1:0]        req_vec;
    logic              gnt_idx;
    logic              gnt_valid;

    assign req_vec = {M1_REQ, M0_REQ};

    rr_arb2 u_arb (
        .req       (req_vec),
        .last      (last_reg),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // Next-state and next-output logic
    always_comb begin
        state_next  = state_reg;
        last_next   = last_reg;
        winner_next = winner_reg;
        cnt_next    = cnt_reg;
        cs_next     = 1'b0;
        wr_rd_next  = wr_rd_reg;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        ack_set     = 1'b0;
        rd_capture  = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (gnt_valid) begin
                    winner_next = gnt_idx;
                    last_next   = gnt_idx;
                    wr_rd_next  = gnt_idx ? M1_WR_RD : M0_WR_RD;
                    addr_next   = gnt_idx ? M1_ADDR  : M0_ADDR;
                    wdata_next  = gnt_idx ? M1_WDATA : M0_WDATA;
                    // CS is registered, so it is raised here to be high
                    // throughout the ACCESS cycle.
                    cs_next     = 1'b1;
                    state_next  = S_ACCESS;
                end
            end
            S_ACCESS: begin
                cnt_next   = LAT_LOAD;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                cnt_next = cnt_reg - CNT_ONE;
                // "<=" rather than "==" so a zero count can never wrap and
                // stall the bus.
                if (cnt_reg <= CNT_ONE) begin
                    state_next = S_DONE;
                    ack_set    = 1'b1;
                    rd_capture = (wr_rd_reg == BUS_RD);
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Sequencer and memory-side registers
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg  <= S_IDLE;
            last_reg   <= 1'b1;
            winner_reg <= 1'b0;
            cnt_reg    <= '0;
            cs_reg     <= 1'b0;
            wr_rd_reg  <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            last_reg   <= last_next;
            winner_reg <= winner_next;
            cnt_reg    <= cnt_next;
            cs_reg     <= cs_next;
            wr_rd_reg  <= wr_rd_next;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
            busy_reg   <= (state_next != S_IDLE);
        end
    end

    // Per-master ACK pulse and read-data holding register
    for (genvar gi = 0; gi < 2; gi++) begin : gen_master
        localparam logic IDX = 1'(gi);
        logic              ack_q;
        logic [DATA_W-1:0] rdata_q;

        always_ff @(posedge CLK) begin
            if (!RST) begin
                ack_q   <= 1'b0;
                rdata_q <= '0;
            end else begin
                ack_q <= ack_set && (winner_reg == IDX);
                // RDATA only moves on a read completion for this master;
                // otherwise it holds the last value read.
                if (rd_capture && (winner_reg == IDX)) begin
                    rdata_q <= Data_BUS_READ;
                end
            end
        end
    end

    assign M0_ACK         = gen_master[0].ack_q;
    assign M0_RDATA       = gen_master[0].rdata_q;
    assign M1_ACK         = gen_master[1].ack_q;
    assign M1_RDATA       = gen_master[1].rdata_q;
    assign CS             = cs_reg;
    assign WR_RD          = wr_rd_reg;
    assign ADDR           = addr_reg;
    assign Data_BUS_WRITE = wdata_reg;
    assign BUSY           = busy_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Scoreboard bench for mem_bus_arbiter. Drivers push the expected read data
//   per master when a request is issued; a negedge monitor pops and compares
//   on every ACK and checks each CS against a transaction-level arbitration
//   model. A second instance with MEM_LAT = 3 covers the longer latency.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int LAT  = 1;
    localparam int LAT3 = 3;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RST = 1'b0;

    // Main DUT stimulus / observation
    logic [1:0]  req = '0;
    logic [1:0]  wr  = '0;
    logic [31:0] addr_i  [2] = '{32'h0, 32'h0};
    logic [31:0] wdata_i [2] = '{32'h0, 32'h0};
    logic        ack0, ack1;
    logic [31:0] rdata0, rdata1;
    logic        cs, wr_rd;
    logic [31:0] bus_addr, bus_wdata;
    logic [31:0] bus_rdata = '0;
    logic        busy;

    // MEM_LAT = 3 instance
    logic        req3 = 1'b0, wr3 = 1'b0;
    logic [31:0] addr3 = '0, wdata3 = '0;
    logic        m1_req3 = 1'b0, m1_wr3 = 1'b0;
    logic [31:0] m1_addr3 = '0, m1_wdata3 = '0;
    logic        ack3_0, ack3_1;
    logic [31:0] rdata3_0, rdata3_1;
    logic        cs3, wr_rd3;
    logic [31:0] addr3_o, wdata3_o;
    logic [31:0] bus_rdata3 = '0;
    logic        busy3;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .CLK(CLK), .RST(RST),
        .M0_REQ(req[0]), .M0_WR_RD(wr[0]), .M0_ADDR(addr_i[0]), .M0_WDATA(wdata_i[0]),
        .M0_ACK(ack0), .M0_RDATA(rdata0),
        .M1_REQ(req[1]), .M1_WR_RD(wr[1]), .M1_ADDR(addr_i[1]), .M1_WDATA(wdata_i[1]),
        .M1_ACK(ack1), .M1_RDATA(rdata1),
        .CS(cs), .WR_RD(wr_rd), .ADDR(bus_addr), .Data_BUS_WRITE(bus_wdata),
        .Data_BUS_READ(bus_rdata), .BUSY(busy)
    );

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT3)) dut3 (
        .CLK(CLK), .RST(RST),
        .M0_REQ(req3), .M0_WR_RD(wr3), .M0_ADDR(addr3), .M0_WDATA(wdata3),
        .M0_ACK(ack3_0), .M0_RDATA(rdata3_0),
        .M1_REQ(m1_req3), .M1_WR_RD(m1_wr3), .M1_ADDR(m1_addr3), .M1_WDATA(m1_wdata3),
        .M1_ACK(ack3_1), .M1_RDATA(rdata3_1),
        .CS(cs3), .WR_RD(wr_rd3), .ADDR(addr3_o), .Data_BUS_WRITE(wdata3_o),
        .Data_BUS_READ(bus_rdata3), .BUSY(busy3)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge CLK) cyc = cyc + 1;

    // ---------------- reference memory and scoreboard ----------------
    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] bus_mem [logic [31:0]];
    logic [31:0] last_rd [2] = '{32'h0, 32'h0};
    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];
    int          ack_m [$];
    int          ack_c [$];

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] bus_rd(input logic [31:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : init_val(a);
    endfunction

    // ---------------- memory model on the bus side ----------------
    logic [31:0] rd_addr = '0;
    int          cs_cyc  = -100;

    always @(negedge CLK) begin
        if (RST && cs) begin
            if (wr_rd) bus_mem[bus_addr] = bus_wdata;
            rd_addr = bus_addr;
            cs_cyc  = cyc;
        end
    end

    // Read data is valid only in the cycle MEM_LAT after CS; otherwise junk.
    always @(posedge CLK) begin
        #1;
        bus_rdata = (cyc == cs_cyc + LAT) ? bus_rd(rd_addr) : ~bus_rd(rd_addr);
    end

    int cs3_cyc = -100;
    int cs3_cnt = 0;

    always @(negedge CLK) begin
        if (RST && cs3) begin
            cs3_cnt++;
            cs3_cyc = cyc;
            chk("lat3_cs_addr", addr3_o, 32'h40);
            chk("lat3_cs_wr_rd", 32'(wr_rd3), 32'(req3 & wr3));
            chk("lat3_cs_wdata", wdata3_o, wdata3);
            chk("lat3_cs_busy", 32'(busy3), 32'd1);
        end
        if (ack3_1) chk("lat3_m1_ack", 32'(ack3_1), 32'd0);
    end

    always @(posedge CLK) begin
        #1;
        bus_rdata3 = (cyc == cs3_cyc + LAT3) ? 32'h3333_ABCD : (32'hFFFF_0000 ^ 32'(cyc));
    end

    // ---------------- monitor ----------------
    logic [1:0] prev_req = '0;
    logic       prev_cs  = 1'b0;
    logic       last_m   = 1'b1;
    logic       pend     = 1'b0;
    int         pend_w   = 0;
    int         pend_cs  = 0;
    int         mon_w    = 0;

    task automatic handle_ack(input int m, input logic [31:0] rd);
        logic [31:0] e;
        chk($sformatf("ack_owner_m%0d", m), 32'(pend && (pend_w == m)), 32'd1);
        chk($sformatf("cs_to_ack_m%0d", m), 32'(cyc - pend_cs), 32'(LAT + 1));
        chk($sformatf("busy_ack_m%0d", m), 32'(busy), 32'd1);
        if ((m == 0 && exp_q0.size() == 0) || (m == 1 && exp_q1.size() == 0)) begin
            tests++;
            fails++;
            $display("FAIL ack_unexpected_m%0d: got ACK expected none (cycle %0d)", m, cyc);
        end else begin
            e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk($sformatf("rdata_m%0d", m), rd, e);
        end
        pend = 1'b0;
        ack_m.push_back(m);
        ack_c.push_back(cyc);
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            last_m  = 1'b1;
            pend    = 1'b0;
            prev_cs = 1'b0;
        end else begin
            if (cs) begin
                chk("cs_single_cycle", 32'(prev_cs), 32'd0);
                chk("cs_has_request", 32'(prev_req != 2'b00), 32'd1);
                // Tie goes to the master not granted last; a lone request wins.
                mon_w = (prev_req == 2'b11) ? int'(!last_m) : int'(prev_req[1]);
                chk("grant_addr", bus_addr, addr_i[mon_w]);
                chk("grant_wr_rd", 32'(wr_rd), 32'(wr[mon_w]));
                chk("grant_wdata", bus_wdata, wdata_i[mon_w]);
                chk("busy_cs", 32'(busy), 32'd1);
                last_m  = 1'(mon_w);
                pend    = 1'b1;
                pend_w  = mon_w;
                pend_cs = cyc;
            end
            if (ack0) handle_ack(0, rdata0);
            if (ack1) handle_ack(1, rdata1);
            prev_cs = cs;
        end
        prev_req = req;
    end

    // ---------------- drivers ----------------
    task automatic issue(input int m, input logic w, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] e;
        if (w) begin
            ref_mem[a] = d;
            e = last_rd[m];
        end else begin
            e = ref_rd(a);
            last_rd[m] = e;
        end
        req[m]     = 1'b1;
        wr[m]      = w;
        addr_i[m]  = a;
        wdata_i[m] = d;
        if (m == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    task automatic wait_ack(input int m);
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if ((m == 0) ? ack0 : ack1) return;
        end
        tests++;
        fails++;
        $display("FAIL ack_timeout_m%0d: got no ACK expected one within 40 cycles", m);
    endtask

    task automatic do_txn(input int m, input logic w, input logic [31:0] a, input logic [31:0] d);
        int t;
        @(posedge CLK); #1;
        t = cyc;
        issue(m, w, a, d);
        wait_ack(m);
        chk($sformatf("req_to_ack_m%0d", m), 32'(cyc - t), 32'(LAT + 2));
        @(posedge CLK); #1;
        req[m] = 1'b0;
    endtask

    task automatic master_rand(input int m, input int n);
        int gap;
        logic [31:0] a;
        @(posedge CLK); #1;
        for (int i = 0; i < n; i++) begin
            a = 32'h200 + 32'h100 * 32'(m) + 32'($urandom_range(0, 15) * 4);
            issue(m, 1'($urandom_range(0, 1)), a, $urandom);
            wait_ack(m);
            @(posedge CLK); #1;
            gap = $urandom_range(0, 2);
            if (gap > 0 || i == n - 1) req[m] = 1'b0;
            repeat (gap) begin
                @(posedge CLK); #1;
            end
        end
    endtask

    task automatic contend(input int m);
        wait_ack(m);
        @(posedge CLK); #1;
        if (m == 0) issue(0, 1'b1, 32'h54, 32'hCAFE_0054);
        else        issue(1, 1'b0, 32'h64, 32'h0);
        wait_ack(m);
        @(posedge CLK); #1;
        req[m] = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_cs"}, 32'(cs), 32'd0);
        chk({tag, "_wr_rd"}, 32'(wr_rd), 32'd0);
        chk({tag, "_addr"}, bus_addr, 32'd0);
        chk({tag, "_wdata"}, bus_wdata, 32'd0);
        chk({tag, "_ack0"}, 32'(ack0), 32'd0);
        chk({tag, "_ack1"}, 32'(ack1), 32'd0);
        chk({tag, "_rdata0"}, rdata0, 32'd0);
        chk({tag, "_rdata1"}, rdata1, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    int base;
    int t3;
    bit got3;

    initial begin
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_outputs_zero("reset");
        @(posedge CLK); #1;
        RST = 1'b1;

        // Single read, M0, memory returns 0xDEADBEEF
        ref_mem[32'h10] = 32'hDEAD_BEEF;
        bus_mem[32'h10] = 32'hDEAD_BEEF;
        $display("[TB] single read M0 @0x10");
        do_txn(0, 1'b0, 32'h10, 32'h0);

        // Single write, M1; its RDATA must stay unchanged
        $display("[TB] single write M1 @0x20");
        do_txn(1, 1'b1, 32'h20, 32'h1234_5678);
        chk("write_mem_content", bus_rd(32'h20), 32'h1234_5678);

        // MEM_LAT = 3 read on the second instance
        $display("[TB] MEM_LAT=3 read");
        @(posedge CLK); #1;
        t3 = cyc;
        cs3_cnt = 0;
        req3 = 1'b1; wr3 = 1'b0; addr3 = 32'h40; wdata3 = 32'h5555_5555;
        got3 = 1'b0;
        for (int i = 0; i < 20 && !got3; i++) begin
            @(negedge CLK);
            if (ack3_0) begin
                got3 = 1'b1;
                chk("lat3_ack_cycle", 32'(cyc - t3), 32'd5);
                chk("lat3_rdata", rdata3_0, 32'h3333_ABCD);
            end
        end
        if (!got3) begin
            tests++;
            fails++;
            $display("FAIL lat3_timeout: got no ACK expected one");
        end
        @(posedge CLK); #1;
        req3 = 1'b0;
        repeat (4) @(negedge CLK);
        chk("lat3_cs_count", 32'(cs3_cnt), 32'd1);
        chk("lat3_m1_rdata", rdata3_1, 32'd0);

        // Contention from reset: grant order M0, M1, M0, M1
        $display("[TB] contention from reset");
        @(posedge CLK); #1;
        RST = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        last_rd[0] = '0;
        last_rd[1] = '0;
        @(posedge CLK); #1;
        issue(0, 1'b0, 32'h50, 32'h0);
        issue(1, 1'b1, 32'h60, 32'hBEEF_0060);
        base = ack_m.size();
        @(posedge CLK); #1;
        RST = 1'b1;
        fork
            contend(0);
            contend(1);
        join
        chk("contend_ack_count", 32'(ack_m.size() - base), 32'd4);
        if (ack_m.size() - base == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("contend_order_%0d", i), 32'(ack_m[base + i]), 32'(i % 2));
                if (i > 0)
                    chk($sformatf("contend_spacing_%0d", i),
                        32'(ack_c[base + i] - ack_c[base + i - 1]), 32'(LAT + 3));
            end
        end

        // Reset in the WAIT state
        $display("[TB] reset mid-transaction");
        @(posedge CLK); #1;
        issue(0, 1'b0, 32'h80, 32'h0);
        for (int i = 0; i < 10 && !cs; i++) @(negedge CLK);
        @(posedge CLK); #1;
        RST = 1'b0;
        req[0] = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check_outputs_zero("midreset");
        exp_q0.delete();
        last_rd[0] = '0;
        last_rd[1] = '0;
        @(posedge CLK); #1;
        RST = 1'b1;
        base = ack_m.size();
        do_txn(1, 1'b0, 32'h24, 32'h0);
        chk("post_reset_acks", 32'(ack_m.size() - base), 32'd1);

        // M0 holds REQ through its ACK: second transaction follows
        $display("[TB] REQ held after ACK");
        @(posedge CLK); #1;
        base = ack_m.size();
        issue(0, 1'b0, 32'h10, 32'h0);
        wait_ack(0);
        @(posedge CLK); #1;
        issue(0, 1'b1, 32'h14, 32'h0A0B_0C0D);
        wait_ack(0);
        @(posedge CLK); #1;
        req[0] = 1'b0;
        repeat (4) @(negedge CLK);
        chk("held_ack_count", 32'(ack_m.size() - base), 32'd2);
        if (ack_m.size() - base >= 2)
            chk("held_ack_spacing", 32'(ack_c[base + 1] - ack_c[base]), 32'(LAT + 3));

        // Randomized traffic from both masters
        $display("[TB] random traffic");
        fork
            master_rand(0, 25);
            master_rand(1, 25);
        join
        repeat (6) @(negedge CLK);
        chk("sb_empty_m0", 32'(exp_q0.size()), 32'd0);
        chk("sb_empty_m1", 32'(exp_q1.size()), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
